ins_line_fill: RTL and testbench

Fills the 256-word instruction line buffer that instruction fetch reads from. When fetch raises `read_enable`, the block streams 64 consecutive quadwords from local store and writes them into `ins_cache[0:255]`, four 32-bit instructions per quadword. It then marks the line valid and pulses `fill_done`. It sits between the local store read port and the fetch stage, on the responder side of the `read_enable` / `ins_cache` interface.

---
 rtl/ins_line_fill_pkg.sv | 18 +
 rtl/ins_line_fill_if.sv | 28 ++
 rtl/ins_line_fill_qw_unpack.sv | 13 +
 rtl/ins_line_fill.sv | 101 ++++++++++
 tb/tb_ins_line_fill.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/ins_line_fill_pkg.sv
// Shared SPU fetch-side types and line geometry.
// Latency: none (types and constants only).
// Backpressure: n/a.
package spu_if_pkg;
    localparam int LINE_WORDS  = 256;
    localparam int QW_PER_LINE = LINE_WORDS / 4;
    localparam int LS_AW       = 14;
    localparam int QW_CW       = $clog2(QW_PER_LINE);

    typedef logic [0:31]      instr_t;
    typedef logic [0:127]     qword_t;
    typedef logic [LS_AW-1:0] ls_addr_t;

    typedef enum logic [1:0] {IDLE, FILL, DRAIN, DONE} fill_state_t;

    // Encoding of the no-op used by fetch/decode to pad empty slots.
    localparam instr_t LNOP = 32'h0020_0000;
endpackage

// File: rtl/ins_line_fill_if.sv
// Fetch-request, local-store read port and line-buffer signals of the line filler.
// Latency: none (wiring only).
// Backpressure: ls_gnt stalls the local store request side.
interface ins_line_fill_if;
    import spu_if_pkg::*;

    logic     read_enable;
    ls_addr_t line_addr;
    logic     flush;
    logic     ls_rd_en;
    ls_addr_t ls_addr;
    logic     ls_gnt;
    qword_t   ls_rdata;
    instr_t   ins_cache [0:LINE_WORDS-1];
    logic     line_valid;
    logic     fill_busy;
    logic     fill_done;

    modport master (
        output read_enable, line_addr, flush, ls_gnt, ls_rdata,
        input  ls_rd_en, ls_addr, ins_cache, line_valid, fill_busy, fill_done
    );

    modport slave (
        input  read_enable, line_addr, flush, ls_gnt, ls_rdata,
        output ls_rd_en, ls_addr, ins_cache, line_valid, fill_busy, fill_done
    );
endinterface

// File: rtl/ins_line_fill_qw_unpack.sv
// Splits a quadword into four instructions, word 0 in bits [0:31].
// Latency: combinational.
// Backpressure: none.
module qw_unpack
    import spu_if_pkg::*;
(
    input  qword_t qw,
    output instr_t words [0:3]
);
    for (genvar k = 0; k < 4; k++) begin : g_word
        assign words[k] = qw[32*k +: 32];
    end
endmodule

// File: rtl/ins_line_fill.sv
// Streams 64 local-store quadwords into the 256-word instruction line buffer.
// Latency: 66 cycles request-to-valid with continuous grants, +1 per ungranted cycle.
// Backpressure: address and ls_rd_en held until ls_gnt; flush aborts immediately.
module ins_line_fill
    import spu_if_pkg::*;
(
    input logic            clk,
    input logic            reset,
    ins_line_fill_if.slave bus
);
    fill_state_t      state;
    ls_addr_t         base;
    logic [QW_CW-1:0] issue_cnt;
    logic [QW_CW-1:0] ret_cnt;
    logic             pend;
    logic             grant;
    logic             accept;
    instr_t           ret_words [0:3];

    // Flush must kill the request in the same cycle so no return is left in flight.
    assign bus.ls_rd_en = (state == FILL) && !bus.flush;
    assign bus.ls_addr  = base + ls_addr_t'(issue_cnt);
    assign grant        = bus.ls_rd_en && bus.ls_gnt;
    assign accept       = (state == IDLE) && bus.read_enable && !bus.flush;

    qw_unpack u_unpack (
        .qw    (bus.ls_rdata),
        .words (ret_words)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            base           <= '0;
            issue_cnt      <= '0;
            bus.fill_busy  <= 1'b0;
            bus.fill_done  <= 1'b0;
            bus.line_valid <= 1'b0;
        end else begin
            bus.fill_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state          <= FILL;
                        base           <= bus.line_addr;
                        issue_cnt      <= '0;
                        bus.line_valid <= 1'b0;
                        bus.fill_busy  <= 1'b1;
                    end
                end
                FILL: begin
                    if (bus.flush) begin
                        state         <= IDLE;
                        bus.fill_busy <= 1'b0;
                    end else if (grant) begin
                        issue_cnt <= issue_cnt + 1'b1;
                        if (issue_cnt == QW_CW'(QW_PER_LINE - 1))
                            state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (bus.flush) begin
                        state         <= IDLE;
                        bus.fill_busy <= 1'b0;
                    end else if (pend) begin
                        state          <= DONE;
                        bus.fill_busy  <= 1'b0;
                        bus.fill_done  <= 1'b1;
                        bus.line_valid <= 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend    <= 1'b0;
            ret_cnt <= '0;
        end else begin
            pend <= grant;
            if (accept)
                ret_cnt <= '0;
            else if (pend)
                ret_cnt <= ret_cnt + 1'b1;
        end
    end

    // Returns land in request order, so ret_cnt alone selects the quad slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LINE_WORDS; i++)
                bus.ins_cache[i] <= '0;
        end else if (pend) begin
            for (int k = 0; k < 4; k++)
                bus.ins_cache[{ret_cnt, 2'(k)}] <= ret_words[k];
        end
    end
endmodule

// File: tb/tb_ins_line_fill.sv
// Scoreboard bench for ins_line_fill: expected grant addresses, completion cycles
// and line bases are queued at stimulus time and checked by a negedge monitor.
module tb_ins_line_fill;
    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   errors;

    ins_line_fill_if ifc ();

    ins_line_fill dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    logic [13:0] exp_addr [$];
    int          exp_done [$];
    logic [13:0] exp_base [$];

    bit          gnt_toggle;
    int          gnt_ref;
    logic        ls_g;
    logic [13:0] ls_a;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [0:127] qw_of(input logic [13:0] a);
        logic [31:0] n;
        n = {16'b0, a, 2'b00};
        return {n, n + 32'd1, n + 32'd2, n + 32'd3};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cyc %0d)", name, got, exp, cyc);
        end
    endtask

    // Local store model: data one cycle after a grant. In toggle mode the grant
    // is high on even cycles counted from the request cycle, so cycle 1 is a stall.
    always @(posedge clk) begin
        ls_g = ifc.ls_rd_en && ifc.ls_gnt;
        ls_a = ifc.ls_addr;
        #1;
        ifc.ls_rdata = ls_g ? qw_of(ls_a) : '0;
        ifc.ls_gnt   = gnt_toggle ? (((cyc - gnt_ref) % 2) == 0) : 1'b1;
    end

    always @(negedge clk) begin
        if (reset) begin
            if (ifc.ls_rd_en && ifc.ls_gnt) begin
                if (exp_addr.size() == 0) chk("unexpected_grant", 32'(ifc.ls_addr), 32'hFFFF_FFFF);
                else chk("grant_addr", 32'(ifc.ls_addr), 32'(exp_addr.pop_front()));
            end
            if (ifc.fill_done) begin
                if (exp_done.size() == 0 || exp_base.size() == 0) begin
                    chk("unexpected_fill_done", 32'(cyc), 32'hFFFF_FFFF);
                end else begin
                    logic [13:0] b;
                    logic [13:0] n;
                    chk("fill_done_cycle", 32'(cyc), 32'(exp_done.pop_front()));
                    chk("line_valid_at_done", 32'(ifc.line_valid), 32'd1);
                    b = exp_base.pop_front();
                    for (int i = 0; i < 256; i++) begin
                        n = b + 14'(i / 4);
                        chk($sformatf("ins_cache[%0d]", i), ifc.ins_cache[i],
                            {16'b0, n, 2'b00} + 32'(i % 4));
                    end
                end
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Called in cycle 0; returns in cycle 1 of the fill.
    task automatic start_fill(input logic [13:0] b, input bit tog, input int n_addr, input int done_off);
        gnt_toggle = tog;
        gnt_ref    = cyc;
        for (int i = 0; i < n_addr; i++) exp_addr.push_back(b + 14'(i));
        if (done_off > 0) begin
            exp_done.push_back(cyc + done_off);
            exp_base.push_back(b);
        end
        ifc.line_addr   = b;
        ifc.read_enable = 1'b1;
        step();
        ifc.read_enable = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        int nz;
        nz = 0;
        for (int i = 0; i < 256; i++) if (ifc.ins_cache[i] !== '0) nz++;
        chk({tag, "_ls_rd_en"},   32'(ifc.ls_rd_en),   32'd0);
        chk({tag, "_ls_addr"},    32'(ifc.ls_addr),    32'd0);
        chk({tag, "_fill_busy"},  32'(ifc.fill_busy),  32'd0);
        chk({tag, "_fill_done"},  32'(ifc.fill_done),  32'd0);
        chk({tag, "_line_valid"}, 32'(ifc.line_valid), 32'd0);
        chk({tag, "_cache_nonzero_words"}, 32'(nz), 32'd0);
    endtask

    initial begin
        int c;
        checks          = 0;
        errors          = 0;
        cyc             = 0;
        gnt_toggle      = 1'b0;
        gnt_ref         = 0;
        reset           = 1'b0;
        ifc.read_enable = 1'b0;
        ifc.line_addr   = '0;
        ifc.flush       = 1'b0;
        ifc.ls_gnt      = 1'b1;
        ifc.ls_rdata    = '0;

        step(3);
        @(negedge clk);
        check_reset_state("por");
        step();
        reset = 1'b1;
        step(2);

        // Full line, continuous grants: done at cycle 66.
        start_fill(14'h0100, 1'b0, 64, 66);
        step(80);

        // Line straddling the top of local store.
        start_fill(14'h3FE0, 1'b0, 64, 66);
        step(80);

        // Alternating grants: 64 stall cycles added, done at cycle 130.
        start_fill(14'h0200, 1'b1, 64, 130);
        step(140);
        gnt_toggle = 1'b0;

        // Flush in the cycle of grant 30: only 29 grants, no completion.
        start_fill(14'h0500, 1'b0, 29, 0);
        step(29);
        ifc.flush = 1'b1;
        @(negedge clk);
        chk("flush_ls_rd_en", 32'(ifc.ls_rd_en), 32'd0);
        step();
        ifc.flush = 1'b0;
        @(negedge clk);
        chk("flush_fill_busy", 32'(ifc.fill_busy), 32'd0);
        chk("flush_line_valid", 32'(ifc.line_valid), 32'd0);
        step(2);
        start_fill(14'h0500, 1'b0, 64, 66);
        step(80);

        // read_enable held: second fill sampled at edge 67 (first fill's cycle 67).
        c = cyc;
        for (int i = 0; i < 64; i++) exp_addr.push_back(14'h0040 + 14'(i));
        for (int i = 0; i < 64; i++) exp_addr.push_back(14'h0040 + 14'(i));
        exp_done.push_back(c + 66);
        exp_done.push_back(c + 67 + 66);
        exp_base.push_back(14'h0040);
        exp_base.push_back(14'h0040);
        ifc.line_addr   = 14'h0040;
        ifc.read_enable = 1'b1;
        step(68);
        ifc.read_enable = 1'b0;
        @(negedge clk);
        chk("refill_line_valid_cleared", 32'(ifc.line_valid), 32'd0);
        chk("refill_busy", 32'(ifc.fill_busy), 32'd1);
        step(80);

        // Request together with flush in IDLE is dropped.
        ifc.line_addr   = 14'h0700;
        ifc.read_enable = 1'b1;
        ifc.flush       = 1'b1;
        step();
        ifc.read_enable = 1'b0;
        ifc.flush       = 1'b0;
        @(negedge clk);
        chk("idle_flush_busy", 32'(ifc.fill_busy), 32'd0);
        chk("idle_flush_rd_en", 32'(ifc.ls_rd_en), 32'd0);
        step(5);

        // Asynchronous reset in the middle of a fill.
        start_fill(14'h0900, 1'b0, 20, 0);
        step(20);
        reset = 1'b0;
        #1;
        check_reset_state("midrun");
        step();
        reset = 1'b1;
        step(3);

        chk("leftover_grants", 32'(exp_addr.size()), 32'd0);
        chk("leftover_done", 32'(exp_done.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
